// File: rtl/tl_rx_malformed_check_ctrl_pkg.sv
// Shared types for the RX malformed-TLP check controller: header type codes,
// max-payload codes and the controller FSM state encoding.
package tl_rx_malformed_check_ctrl_pkg;

    typedef enum logic [2:0] {
        TypMemory  = 3'b000,
        TypIo      = 3'b001,
        TypCfg0    = 3'b010,
        TypCfg1    = 3'b011,
        TypCpl     = 3'b100,
        TypMessage = 3'b101
    } tl_typ_e;

    typedef enum logic [2:0] {
        Mps128  = 3'b000,
        Mps256  = 3'b001,
        Mps512  = 3'b010,
        Mps1024 = 3'b011,
        Mps2048 = 3'b100,
        Mps4096 = 3'b101
    } tl_mps_e;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCheck,
        StReport
    } ctrl_state_e;

    localparam int unsigned MalfCntW = 16;

endpackage

// File: rtl/tl_rx_malformed_check_ctrl_if.sv
// Bundle of parser, checker and error-logger signals seen by the check controller.
// The slave modport is the controller side; master is the environment side.
interface tl_rx_malformed_check_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned BEAT_DW    = 8
);
    import tl_rx_malformed_check_ctrl_pkg::*;

    localparam int unsigned LastW = $clog2(BEAT_DW);

    logic                  i_sop;
    logic                  i_beat_valid;
    logic                  i_eop;
    logic                  i_has_data;
    logic [DATA_WIDTH-1:0] i_length;
    logic [2:0]            i_typ;
    logic [1:0]            i_attr;
    logic [1:0]            i_at;
    logic [2:0]            i_tc;
    logic                  o_rx_ready;
    logic                  o_malformed_en;
    logic [LastW-1:0]      o_last_rcv_data;
    logic                  o_rcv_done;
    logic [2:0]            o_typ;
    logic [1:0]            o_attr;
    logic [1:0]            o_at;
    logic [2:0]            o_tc;
    logic [DATA_WIDTH-1:0] o_length;
    logic                  i_malformed_error;
    logic                  o_tlp_commit;
    logic                  o_tlp_drop;
    logic                  o_err_valid;
    logic                  i_err_ready;
    logic [2:0]            o_err_hdr_typ;
    logic [MalfCntW-1:0]   o_malf_cnt;

    modport slave (
        input  i_sop, i_beat_valid, i_eop, i_has_data, i_length,
        input  i_typ, i_attr, i_at, i_tc, i_malformed_error, i_err_ready,
        output o_rx_ready, o_malformed_en, o_last_rcv_data, o_rcv_done,
        output o_typ, o_attr, o_at, o_tc, o_length,
        output o_tlp_commit, o_tlp_drop, o_err_valid, o_err_hdr_typ, o_malf_cnt
    );

    modport master (
        output i_sop, i_beat_valid, i_eop, i_has_data, i_length,
        output i_typ, i_attr, i_at, i_tc, i_malformed_error, i_err_ready,
        input  o_rx_ready, o_malformed_en, o_last_rcv_data, o_rcv_done,
        input  o_typ, o_attr, o_at, o_tc, o_length,
        input  o_tlp_commit, o_tlp_drop, o_err_valid, o_err_hdr_typ, o_malf_cnt
    );

endinterface

// File: rtl/tl_rx_malformed_check_ctrl_beat_counter.sv
// Saturating data-beat counter with the expected beat count latched at SOP;
// last_beat_o flags that the beat being counted now would complete the TLP.
module tl_rx_malformed_check_ctrl_beat_counter #(
    parameter int unsigned BEAT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  load_i,
    input  logic [BEAT_CNT_W-1:0] exp_beats_i,
    input  logic                  beat_i,
    output logic                  last_beat_o
);

    logic [BEAT_CNT_W-1:0] cnt_q;
    logic [BEAT_CNT_W-1:0] exp_q;
    logic [BEAT_CNT_W:0]   cnt_inc;

    // One bit wider so a saturated count never aliases onto a small expected value.
    assign cnt_inc     = {1'b0, cnt_q} + (BEAT_CNT_W + 1)'(1);
    assign last_beat_o = (cnt_inc == {1'b0, exp_q});

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
            exp_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            exp_q <= exp_beats_i;
        end else if (beat_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + BEAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/tl_rx_malformed_check_ctrl.sv
// RX write-path malformed-TLP check sequencer: header capture, beat counting, one-cycle
// checker strobe, commit/drop and error reporting. Optional TL_RX_MALF_CNT_EN drop counter.
module tl_rx_malformed_check_ctrl
    import tl_rx_malformed_check_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned BEAT_DW    = 8,
    parameter int unsigned BEAT_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          arst,
    tl_rx_malformed_check_ctrl_if.slave   bus
);

    localparam int unsigned LastW     = $clog2(BEAT_DW);
    localparam int unsigned BeatShift = $clog2(BEAT_DW);

    ctrl_state_e           state_q;
    logic                  en_q;
    logic                  done_q;
    logic [LastW-1:0]      last_q;
    logic [2:0]            typ_q;
    logic [1:0]            attr_q;
    logic [1:0]            at_q;
    logic [2:0]            tc_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic                  err_valid_q;
    logic [2:0]            err_typ_q;

    logic [DATA_WIDTH:0]   len_dw;
    logic [DATA_WIDTH:0]   len_round;
    logic [DATA_WIDTH:0]   exp_full;
    logic [BEAT_CNT_W-1:0] exp_beats;
    logic [BEAT_CNT_W-1:0] exp_beats_load;
    logic [LastW-1:0]      last_d;
    logic                  cnt_load;
    logic                  cnt_beat;
    logic                  cnt_last_beat;

    // Length 0 encodes the full 2**DATA_WIDTH DW payload.
    assign len_dw    = (bus.i_length == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, bus.i_length};
    assign len_round = len_dw + (DATA_WIDTH + 1)'(BEAT_DW - 1);
    assign exp_full  = len_round >> BeatShift;
    assign exp_beats = BEAT_CNT_W'(exp_full);
    assign last_d    = bus.i_length[LastW-1:0] - LastW'(1);

    assign cnt_load       = (state_q == StIdle) && bus.i_sop;
    assign exp_beats_load = (bus.i_has_data && !bus.i_eop) ? exp_beats : '0;
    assign cnt_beat       = (state_q == StData) && !bus.i_sop && bus.i_beat_valid;

    tl_rx_malformed_check_ctrl_beat_counter #(
        .BEAT_CNT_W (BEAT_CNT_W)
    ) u_beat_cnt (
        .clk         (clk),
        .arst        (arst),
        .load_i      (cnt_load),
        .exp_beats_i (exp_beats_load),
        .beat_i      (cnt_beat),
        .last_beat_o (cnt_last_beat)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= StIdle;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= '0;
            typ_q       <= '0;
            attr_q      <= '0;
            at_q        <= '0;
            tc_q        <= '0;
            len_q       <= '0;
            err_valid_q <= 1'b0;
            err_typ_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.i_sop) begin
                        typ_q  <= bus.i_typ;
                        attr_q <= bus.i_attr;
                        at_q   <= bus.i_at;
                        tc_q   <= bus.i_tc;
                        len_q  <= bus.i_length;
                        last_q <= last_d;
                        if (bus.i_has_data && !bus.i_eop) begin
                            state_q <= StData;
                        end else begin
                            state_q <= StCheck;
                            en_q    <= 1'b1;
                            done_q  <= bus.i_eop && !bus.i_has_data;
                        end
                    end
                end
                StData: begin
                    // A new header before EOP truncates the current TLP; it is left unconsumed.
                    if (bus.i_sop) begin
                        state_q <= StCheck;
                        en_q    <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (bus.i_beat_valid && bus.i_eop) begin
                        state_q <= StCheck;
                        en_q    <= 1'b1;
                        done_q  <= cnt_last_beat;
                    end
                end
                StCheck: begin
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.i_malformed_error) begin
                        err_valid_q <= 1'b1;
                        err_typ_q   <= typ_q;
                        state_q     <= StReport;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StReport: begin
                    if (bus.i_err_ready) begin
                        err_valid_q <= 1'b0;
                        err_typ_q   <= '0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_rx_ready      = (state_q == StIdle) || ((state_q == StData) && !bus.i_sop);
    assign bus.o_malformed_en  = en_q;
    assign bus.o_rcv_done      = done_q;
    assign bus.o_last_rcv_data = last_q;
    assign bus.o_typ           = typ_q;
    assign bus.o_attr          = attr_q;
    assign bus.o_at            = at_q;
    assign bus.o_tc            = tc_q;
    assign bus.o_length        = len_q;
    assign bus.o_tlp_commit    = (state_q == StCheck) && !bus.i_malformed_error;
    assign bus.o_tlp_drop      = (state_q == StCheck) && bus.i_malformed_error;
    assign bus.o_err_valid     = err_valid_q;
    assign bus.o_err_hdr_typ   = err_typ_q;

`ifdef TL_RX_MALF_CNT_EN
    logic [MalfCntW-1:0] malf_cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            malf_cnt_q <= '0;
        end else if (bus.o_tlp_drop && (malf_cnt_q != '1)) begin
            malf_cnt_q <= malf_cnt_q + MalfCntW'(1);
        end
    end

    assign bus.o_malf_cnt = malf_cnt_q;
`else
    assign bus.o_malf_cnt = '0;
`endif

endmodule

// File: tb/tb_tl_rx_malformed_check_ctrl.sv
// Self-checking bench for tl_rx_malformed_check_ctrl: directed scenarios plus random TLPs
// scored against a length/beat-count model. Honours TL_RX_MALF_CNT_EN when defined.
module tb_tl_rx_malformed_check_ctrl;

    logic clk;
    logic arst;
    int   compared;
    int   failed;
    int   drops_model;

    tl_rx_malformed_check_ctrl_if #(.DATA_WIDTH(10), .BEAT_DW(8)) bus ();

    tl_rx_malformed_check_ctrl #(
        .DATA_WIDTH (10),
        .BEAT_DW    (8),
        .BEAT_CNT_W (8)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned len_dw_of(input int unsigned len);
        return (len == 0) ? 1024 : len;
    endfunction

    function automatic int unsigned exp_beats_of(input int unsigned len);
        return (len_dw_of(len) + 7) / 8;
    endfunction

    function automatic int unsigned exp_malf();
`ifdef TL_RX_MALF_CNT_EN
        return (drops_model > 65535) ? 65535 : drops_model;
`else
        return 0;
`endif
    endfunction

    task automatic clear_inputs();
        bus.i_sop             = 1'b0;
        bus.i_beat_valid      = 1'b0;
        bus.i_eop             = 1'b0;
        bus.i_has_data        = 1'b0;
        bus.i_length          = '0;
        bus.i_typ             = '0;
        bus.i_attr            = '0;
        bus.i_at              = '0;
        bus.i_tc              = '0;
        bus.i_malformed_error = 1'b0;
        bus.i_err_ready       = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, bus.o_rx_ready, 1);
        chk({tag, "_en"}, bus.o_malformed_en, 0);
        chk({tag, "_done"}, bus.o_rcv_done, 0);
        chk({tag, "_last"}, bus.o_last_rcv_data, 0);
        chk({tag, "_typ"}, bus.o_typ, 0);
        chk({tag, "_attr"}, {bus.o_attr, bus.o_at, bus.o_tc}, 0);
        chk({tag, "_len"}, bus.o_length, 0);
        chk({tag, "_commit"}, bus.o_tlp_commit, 0);
        chk({tag, "_drop"}, bus.o_tlp_drop, 0);
        chk({tag, "_err_valid"}, bus.o_err_valid, 0);
        chk({tag, "_err_typ"}, bus.o_err_hdr_typ, 0);
        chk({tag, "_malf"}, bus.o_malf_cnt, 0);
    endtask

    // kind: 0 no-data sop&eop, 1/2 data ending with eop on beat nb, 3 truncated by a new
    // sop after nb beats, 4 sop&eop with has_data set (no beats).
    task automatic run_tlp(input int kind, input int unsigned len, input int nb, input bit err,
                           input int hold, input logic [2:0] typ, input logic [1:0] attr,
                           input logic [1:0] at, input logic [2:0] tc);
        int unsigned expb = exp_beats_of(len);
        int unsigned last = (len_dw_of(len) - 1) % 8;
        bit          exp_done;
        bus.i_sop      = 1'b1;
        bus.i_has_data = (kind != 0);
        bus.i_eop      = (kind == 0) || (kind == 4);
        bus.i_length   = len[9:0];
        bus.i_typ      = typ;
        bus.i_attr     = attr;
        bus.i_at       = at;
        bus.i_tc       = tc;
        #1 chk("rdy_idle", bus.o_rx_ready, 1);
        cyc();
        clear_inputs();
        if (kind == 0) begin
            exp_done = 1'b1;
        end else if (kind == 4) begin
            exp_done = 1'b0;
        end else begin
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.i_beat_valid = 1'b0;
                    bus.i_eop        = 1'b0;
                    #1 chk("rdy_gap", bus.o_rx_ready, 1);
                    cyc();
                end
                bus.i_beat_valid = 1'b1;
                bus.i_eop        = (kind != 3) && (b == nb - 1);
                #1 chk("rdy_data", bus.o_rx_ready, 1);
                cyc();
            end
            clear_inputs();
            if (kind == 3) begin
                bus.i_sop          = 1'b1;
                bus.i_beat_valid   = 1'($urandom_range(0, 1));
                bus.i_has_data     = 1'b1;
                bus.i_typ          = ~typ;
                bus.i_length       = ~len[9:0];
                #1 chk("rdy_sop_in_data", bus.o_rx_ready, 0);
                cyc();
                clear_inputs();
                exp_done = 1'b0;
            end else begin
                exp_done = (nb == expb);
            end
        end
        bus.i_malformed_error = err;
        #1;
        chk("chk_en", bus.o_malformed_en, 1);
        chk("chk_done", bus.o_rcv_done, exp_done);
        chk("chk_last", bus.o_last_rcv_data, last);
        chk("chk_typ", bus.o_typ, typ);
        chk("chk_hdr", {bus.o_attr, bus.o_at, bus.o_tc}, {attr, at, tc});
        chk("chk_len", bus.o_length, len[9:0]);
        chk("chk_commit", bus.o_tlp_commit, !err);
        chk("chk_drop", bus.o_tlp_drop, err);
        chk("chk_rdy", bus.o_rx_ready, 0);
        if (err) drops_model++;
        cyc();
        bus.i_malformed_error = 1'b0;
        if (err) begin
            for (int h = 0; h < hold; h++) begin
                #1;
                chk("rep_valid", bus.o_err_valid, 1);
                chk("rep_typ", bus.o_err_hdr_typ, typ);
                chk("rep_rdy", bus.o_rx_ready, 0);
                chk("rep_pulse", {bus.o_malformed_en, bus.o_tlp_commit, bus.o_tlp_drop}, 0);
                cyc();
            end
            bus.i_err_ready = 1'b1;
            #1 chk("rep_accept", {bus.o_err_valid, bus.o_err_hdr_typ}, {1'b1, typ});
            cyc();
            bus.i_err_ready = 1'b0;
        end
        #1;
        chk("post_rdy", bus.o_rx_ready, 1);
        chk("post_idle", {bus.o_malformed_en, bus.o_err_valid, bus.o_tlp_commit, bus.o_tlp_drop},
            0);
        chk("malf_cnt", bus.o_malf_cnt, exp_malf());
    endtask

    initial begin
        compared    = 0;
        failed      = 0;
        drops_model = 0;
        arst        = 1'b1;
        clear_inputs();
        #23;
        check_reset_vals("reset");
        arst = 1'b0;
        cyc();

        // Directed scenarios.
        run_tlp(1, 16, 2, 1'b0, 0, 3'b000, 2'b01, 2'b10, 3'b011);
        run_tlp(2, 16, 1, 1'b1, 0, 3'b000, 2'b00, 2'b00, 3'b000);
        run_tlp(0, 1, 0, 1'b0, 0, 3'b010, 2'b00, 2'b00, 3'b000);
        run_tlp(2, 24, 2, 1'b1, 5, 3'b001, 2'b11, 2'b01, 3'b111);
        run_tlp(3, 32, 1, 1'b1, 1, 3'b000, 2'b10, 2'b00, 3'b010);
        run_tlp(1, 32, 4, 1'b0, 0, 3'b000, 2'b00, 2'b11, 3'b001);
        run_tlp(1, 0, 128, 1'b0, 0, 3'b000, 2'b00, 2'b00, 3'b000);
        run_tlp(1, 9, 2, 1'b0, 0, 3'b100, 2'b00, 2'b00, 3'b000);
        run_tlp(4, 8, 0, 1'b1, 2, 3'b101, 2'b01, 2'b01, 3'b101);

        // Reset while receiving data.
        bus.i_sop      = 1'b1;
        bus.i_has_data = 1'b1;
        bus.i_length   = 10'd64;
        bus.i_typ      = 3'b011;
        cyc();
        clear_inputs();
        bus.i_beat_valid = 1'b1;
        cyc();
        arst = 1'b1;
        #1 check_reset_vals("arst_data");
        clear_inputs();
        #2 arst = 1'b0;
        drops_model = 0;
        cyc();

        // Reset while a report is pending.
        bus.i_sop    = 1'b1;
        bus.i_eop    = 1'b1;
        bus.i_length = 10'd1;
        bus.i_typ    = 3'b101;
        cyc();
        clear_inputs();
        bus.i_malformed_error = 1'b1;
        cyc();
        bus.i_malformed_error = 1'b0;
        #1 chk("arst_rep_pre", bus.o_err_valid, 1);
        arst = 1'b1;
        #1 check_reset_vals("arst_report");
        #2 arst = 1'b0;
        drops_model = 0;
        cyc();
        #1 chk("arst_rep_post", {bus.o_err_valid, bus.o_rx_ready}, 2'b01);

        // Three drops after reset.
        for (int i = 0; i < 3; i++) begin
            run_tlp(0, 4, 0, 1'b1, i, 3'b010, 2'b00, 2'b00, 3'b000);
        end

        // Random TLPs.
        for (int i = 0; i < 40; i++) begin
            int          kind;
            int unsigned len;
            int          nb;
            int unsigned expb;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(0, 1023);
            expb = exp_beats_of(len);
            nb   = 0;
            if (kind == 1) nb = expb;
            else if (kind == 2) nb = ((expb > 1) && ($urandom_range(0, 1) == 1)) ? expb - 1 : expb + 1;
            else if (kind == 3) nb = $urandom_range(1, expb);
            run_tlp(kind, len, nb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    3'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
